datapath_sequencer: RTL

- Microprogrammed controller for the shared-bus register datapath: registers A, B, C, T, accumulator AC and the add/sub ALU.
- Accepts an opcode and repeat count through a start/busy/done handshake.
- Replays the selected micro-op program on the bus-control lines count times, then pulses done.
- Replaces hand-written one-state-per-step control FSMs; program contents live in a small ROM sub-module.

---
 rtl/datapath_sequencer_pkg.sv | 43 ++++
 rtl/datapath_microrom.sv | 52 +++++
 rtl/datapath_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath micro-sequencer: opcodes, micro-word layout, FSM states.
package datapath_sequencer_pkg;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_SWAP = 2'd2;
    localparam logic [1:0] OP_FIB  = 2'd3;

    // Micro-word: 11 control bits plus a flag marking the final step of a program.
    localparam int UWORD_W = 12;
    typedef logic [UWORD_W-1:0] uword_t;

    localparam int BIT_R    = 0;
    localparam int BIT_S    = 1;
    localparam int BIT_RAC  = 2;
    localparam int BIT_RC   = 3;
    localparam int BIT_RB   = 4;
    localparam int BIT_RA   = 5;
    localparam int BIT_WAC  = 6;
    localparam int BIT_WT   = 7;
    localparam int BIT_WC   = 8;
    localparam int BIT_WB   = 9;
    localparam int BIT_WA   = 10;
    localparam int BIT_LAST = 11;

    localparam uword_t M_R    = uword_t'(1) << BIT_R;
    localparam uword_t M_S    = uword_t'(1) << BIT_S;
    localparam uword_t M_RAC  = uword_t'(1) << BIT_RAC;
    localparam uword_t M_RC   = uword_t'(1) << BIT_RC;
    localparam uword_t M_RB   = uword_t'(1) << BIT_RB;
    localparam uword_t M_RA   = uword_t'(1) << BIT_RA;
    localparam uword_t M_WAC  = uword_t'(1) << BIT_WAC;
    localparam uword_t M_WT   = uword_t'(1) << BIT_WT;
    localparam uword_t M_WC   = uword_t'(1) << BIT_WC;
    localparam uword_t M_WB   = uword_t'(1) << BIT_WB;
    localparam uword_t M_WA   = uword_t'(1) << BIT_WA;
    localparam uword_t M_LAST = uword_t'(1) << BIT_LAST;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/datapath_microrom.sv
// Combinational micro-program store: (op, upc) -> {last, control word}.
module datapath_microrom
    import datapath_sequencer_pkg::*;
#(
    parameter int UPC_W = 3
) (
    input  logic [1:0]       op,
    input  logic [UPC_W-1:0] upc,
    output uword_t           word
);

    always_comb begin
        word = '0;
        case (op)
            OP_ADD: begin
                case (int'(upc))
                    0: word = M_RA  | M_WT;
                    1: word = M_RB  | M_S | M_WAC;
                    2: word = M_RAC | M_WC | M_LAST;
                    default: word = '0;
                endcase
            end
            OP_SUB: begin
                case (int'(upc))
                    0: word = M_RA  | M_WT;
                    1: word = M_RB  | M_R | M_WAC;
                    2: word = M_RAC | M_WC | M_LAST;
                    default: word = '0;
                endcase
            end
            OP_SWAP: begin
                case (int'(upc))
                    0: word = M_RA | M_WC;
                    1: word = M_RB | M_WA;
                    2: word = M_RC | M_WB | M_LAST;
                    default: word = '0;
                endcase
            end
            default: begin
                case (int'(upc))
                    0: word = M_RA  | M_WT;
                    1: word = M_RB  | M_S | M_WAC;
                    2: word = M_RAC | M_WC;
                    3: word = M_RB  | M_WA;
                    4: word = M_RC  | M_WB | M_LAST;
                    default: word = '0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Microprogrammed bus controller: replays a ROM program count times, then pulses done.
//   state | meaning
//   IDLE  | outputs 0, waiting for start
//   RUN   | busy, driving ROM[op_r][upc] onto the control lines
//   DONE  | one-cycle done pulse, start ignored
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int UPC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wa,
    output logic             wb,
    output logic             wc,
    output logic             wt,
    output logic             wac,
    output logic             ra,
    output logic             rb,
    output logic             rc,
    output logic             rac,
    output logic             s,
    output logic             r
);

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] iter_r;
    logic [UPC_W-1:0] upc;
    uword_t           word;
    logic             last_step;
    logic             run;

    datapath_microrom #(.UPC_W(UPC_W)) u_rom (
        .op   (op_r),
        .upc  (upc),
        .word (word)
    );

    // The upc ceiling also ends an iteration so a missing LAST flag cannot loop forever.
    assign last_step = word[BIT_LAST] || (upc == {UPC_W{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_r   <= '0;
            iter_r <= '0;
            upc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        iter_r <= (count == '0) ? CNT_W'(1) : count;
                        upc    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (!last_step) begin
                        upc <= upc + UPC_W'(1);
                    end else if (iter_r > CNT_W'(1)) begin
                        upc    <= '0;
                        iter_r <= iter_r - CNT_W'(1);
                    end else begin
                        upc   <= '0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign run  = (state == RUN);
    assign busy = run;
    assign done = (state == DONE);

    assign wa  = run & word[BIT_WA];
    assign wb  = run & word[BIT_WB];
    assign wc  = run & word[BIT_WC];
    assign wt  = run & word[BIT_WT];
    assign wac = run & word[BIT_WAC];
    assign ra  = run & word[BIT_RA];
    assign rb  = run & word[BIT_RB];
    assign rc  = run & word[BIT_RC];
    assign rac = run & word[BIT_RAC];
    assign s   = run & word[BIT_S];
    assign r   = run & word[BIT_R];

    a_bus_single_driver: assert property (@(posedge clk) disable iff (reset)
        $onehot0({ra, rb, rc, rac}));
    a_alu_select_excl: assert property (@(posedge clk) disable iff (reset)
        !(s && r));
    a_wac_needs_alu: assert property (@(posedge clk) disable iff (reset)
        !wac || (s ^ r));
    a_busy_done_excl: assert property (@(posedge clk) disable iff (reset)
        !(busy && done));

endmodule
